conv_rstl_pool_reader: RTL and testbench

Read-side companion of the convolution-result memory write counter. After a convolution pass completes, this block reads the IMG_H x IMG_W result memory in 2x2 / stride-2 pooling-window order and streams the samples to the pooling/next-layer stage over a valid/ready interface. It generates synchronous-RAM read addresses, absorbs the 1-cycle RAM read latency, and honours output backpressure without losing data.

---
 rtl/conv_rstl_pool_reader_if.sv | 29 ++
 rtl/conv_rstl_pool_reader.sv | 190 +++++++++++++++++++
 tb/tb_conv_rstl_pool_reader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_rstl_pool_reader_if.sv
// Memory read port and output stream of conv_rstl_pool_reader.
// master = the reader; slave = the RAM / downstream side.
interface conv_rstl_pool_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last_win;
  logic              out_last;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    output out_data, out_valid, out_last_win, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    input  out_data, out_valid, out_last_win, out_last,
    output out_ready
  );
endinterface

// File: rtl/conv_rstl_pool_reader.sv
// Reads the IMG_H x IMG_W convolution result RAM in 2x2/stride-2 window order and streams it.
// Optional CONV_RSTL_MAXPOOL_EN folds each window to its signed max (one beat per window).
module conv_rstl_pool_reader #(
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_busy,
  output logic o_done,
  conv_rstl_pool_reader_if.master bus
);
  // state   | meaning
  // S_IDLE  | waiting for start
  // S_ISSUE | issuing reads in window order
  // S_DRAIN | last read issued, emptying in-flight read and FIFO
  // S_DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam int WC_W = $clog2(IMG_W/2 + 1);
  localparam int WR_W = $clog2(IMG_H/2 + 1);
  localparam logic [WC_W-1:0]   WC_LAST   = WC_W'(IMG_W/2 - 1);
  localparam logic [WR_W-1:0]   WR_LAST   = WR_W'(IMG_H/2 - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW2_STEP = ADDR_W'(2*IMG_W);
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(2);

  state_t            r_state, w_state_nxt;
  logic [WR_W-1:0]   r_wr;
  logic [WC_W-1:0]   r_wc;
  logic              r_dy, r_dx;
  logic [ADDR_W-1:0] r_row_base, r_col_off, w_addr;
  logic              w_issue, w_room, w_at_last, w_drained;
  logic [2:0]        w_occ;

  logic              r_inflight, r_inf_lw, r_inf_last;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic              r_fifo_lw   [2];
  logic              r_fifo_last [2];
  logic              r_wptr, r_rptr;
  logic [1:0]        r_count;
  logic              w_fifo_valid, w_pop, w_out_empty;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_lw, w_head_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_issue && w_at_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Slots already committed next cycle: FIFO entries + read in flight - entry leaving now.
  assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room    = (w_occ < 3'd2);
  assign w_issue   = (r_state == S_ISSUE) && w_room;
  assign w_at_last = (r_wr == WR_LAST) && (r_wc == WC_LAST) && r_dy && r_dx;
  assign w_drained = (r_count == 2'd0) && !r_inflight && w_out_empty;

  assign w_addr = r_row_base + (r_dy ? ROW_STEP : '0) + r_col_off
                + {{(ADDR_W-1){1'b0}}, r_dx};

  assign bus.mem_rd_en = w_issue;
  assign bus.mem_addr  = w_issue ? w_addr : '0;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);

  // Window walker; row base accumulates 2*IMG_W per window row instead of multiplying.
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE)) begin
      r_wr       <= '0;
      r_wc       <= '0;
      r_dy       <= 1'b0;
      r_dx       <= 1'b0;
      r_row_base <= '0;
      r_col_off  <= '0;
    end else if (w_issue) begin
      r_dx <= ~r_dx;
      if (r_dx) begin
        r_dy <= ~r_dy;
        if (r_dy) begin
          if (r_wc == WC_LAST) begin
            r_wc       <= '0;
            r_col_off  <= '0;
            r_wr       <= r_wr + 1'b1;
            r_row_base <= r_row_base + ROW2_STEP;
          end else begin
            r_wc      <= r_wc + 1'b1;
            r_col_off <= r_col_off + COL_STEP;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight     <= 1'b0;
      r_inf_lw       <= 1'b0;
      r_inf_last     <= 1'b0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_lw[0]   <= 1'b0;
      r_fifo_lw[1]   <= 1'b0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      r_inf_lw   <= r_dy & r_dx;
      r_inf_last <= w_at_last;
      if (r_inflight) begin
        r_fifo_data[r_wptr] <= bus.mem_rdata;
        r_fifo_lw[r_wptr]   <= r_inf_lw;
        r_fifo_last[r_wptr] <= r_inf_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_fifo_valid = (r_count != 2'd0);
  assign w_head_data  = r_fifo_data[r_rptr];
  assign w_head_lw    = r_fifo_lw[r_rptr];
  assign w_head_last  = r_fifo_last[r_rptr];

`ifdef CONV_RSTL_MAXPOOL_EN
  logic [DATA_W-1:0] r_max, r_out_data, w_max_nxt;
  logic              r_first, r_out_valid, r_out_last;

  // Samples are folded only when the window result has somewhere to go.
  assign w_pop     = w_fifo_valid && (!r_out_valid || bus.out_ready);
  assign w_max_nxt = (r_first || ($signed(w_head_data) > $signed(r_max))) ? w_head_data : r_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max       <= '0;
      r_first     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_max   <= w_max_nxt;
        r_first <= w_head_lw;
      end
      if (w_pop && w_head_lw) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_max_nxt;
        r_out_last  <= w_head_last;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_valid ? r_out_data : '0;
  assign bus.out_last_win = r_out_valid;
  assign bus.out_last     = r_out_valid && r_out_last;
  assign w_out_empty      = !r_out_valid;
`else
  assign w_pop            = w_fifo_valid && bus.out_ready;
  assign bus.out_valid    = w_fifo_valid;
  assign bus.out_data     = w_fifo_valid ? w_head_data : '0;
  assign bus.out_last_win = w_fifo_valid && w_head_lw;
  assign bus.out_last     = w_fifo_valid && w_head_last;
  assign w_out_empty      = 1'b1;
`endif

endmodule

// File: tb/tb_conv_rstl_pool_reader.sv
// Bench for conv_rstl_pool_reader: 26x26 frames under random backpressure against a window-order
// model, plus a 4x4 instance checked from a vector table (raw or CONV_RSTL_MAXPOOL_EN build).
module tb_conv_rstl_pool_reader;
  localparam int W = 26, H = 26, DW = 8, AW = 10, NPIX = W*H;
`ifdef CONV_RSTL_MAXPOOL_EN
  localparam int NBEAT = NPIX/4, NBEAT_S = 4;
`else
  localparam int NBEAT = NPIX, NBEAT_S = 16;
`endif

  typedef struct packed { logic [DW-1:0] d; logic lw; logic last; } beat_t;
  typedef struct { int addr; logic [DW-1:0] ram; bit lw; bit last; } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic start, busy, done, start_s, busy_s, done_s;
  always #5 clk = ~clk;

  conv_rstl_pool_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  conv_rstl_pool_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();

  conv_rstl_pool_reader #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst), .i_start(start), .o_busy(busy), .o_done(done), .bus(bus.master));
  conv_rstl_pool_reader #(.IMG_W(4), .IMG_H(4), .DATA_W(DW), .ADDR_W(AW)) u_small (
    .clk(clk), .rst(rst), .i_start(start_s), .o_busy(busy_s), .o_done(done_s), .bus(bus_s.master));

  logic [DW-1:0] mem [NPIX];
  logic [DW-1:0] mem_s [16];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  always @(posedge clk) if (bus_s.mem_rd_en) bus_s.mem_rdata <= mem_s[bus_s.mem_addr[3:0]];

  int checks = 0, errors = 0;
  int exp_addr_q[$];
  beat_t exp_q[$];
  int n_acc, n_issued, n_done;
  int ready_pct = 100, last_pulse = -1;
  bit start_req = 0, repulse_en = 0, start_on_done = 0, mon_en = 0, stall_prev = 0;
  beat_t held, eb;
  int ea;
  bit cap_s = 0;
  int addr_s[$];
  beat_t beat_s[$];
  int n_done_s;
  vec_t vec_s[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Input driver: start pulses and out_ready, changed 1 time unit after the rising edge.
  initial begin
    start = 1'b0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (start_req) begin
        start = 1'b1;
        start_req = 0;
      end else if (repulse_en && (n_acc == 10 || n_acc == 300) && last_pulse != n_acc) begin
        start = 1'b1;
        last_pulse = n_acc;
      end else if (start_on_done && done) begin
        start = 1'b1;
        start_on_done = 0;
      end
      if (ready_pct >= 100) bus.out_ready = 1'b1;
      else if (ready_pct <= 0) bus.out_ready = 1'b0;
      else bus.out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Reference: window-order traversal computed directly from the address formula.
  task automatic build_model();
    int a;
    bit lastw;
    beat_t b;
`ifdef CONV_RSTL_MAXPOOL_EN
    int v, mx;
`endif
    exp_addr_q.delete();
    exp_q.delete();
    for (int wr = 0; wr < H/2; wr++) begin
      for (int wc = 0; wc < W/2; wc++) begin
        lastw = (wr == H/2-1) && (wc == W/2-1);
`ifdef CONV_RSTL_MAXPOOL_EN
        mx = -1000;
`endif
        for (int k = 0; k < 4; k++) begin
          a = (2*wr + k/2)*W + 2*wc + k%2;
          exp_addr_q.push_back(a);
`ifdef CONV_RSTL_MAXPOOL_EN
          v = int'($signed(mem[a]));
          if (v > mx) mx = v;
`else
          b.d = mem[a];
          b.lw = (k == 3);
          b.last = lastw && (k == 3);
          exp_q.push_back(b);
`endif
        end
`ifdef CONV_RSTL_MAXPOOL_EN
        b.d = DW'(mx);
        b.lw = 1'b1;
        b.last = lastw;
        exp_q.push_back(b);
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_rd_en) begin
`ifndef CONV_RSTL_MAXPOOL_EN
        chk("occupancy", (n_issued - n_acc) <= 2, 1'b1);
`endif
        chk("rd_addr_count", exp_addr_q.size() != 0, 1'b1);
        if (exp_addr_q.size() != 0) begin
          ea = exp_addr_q.pop_front();
          chk("rd_addr", bus.mem_addr, ea);
        end
        n_issued++;
      end
      if (stall_prev)
        chk("stall_hold", {bus.out_valid, bus.out_data, bus.out_last_win, bus.out_last}, {1'b1, held});
      if (bus.out_valid && !bus.out_ready) begin
        stall_prev = 1;
        held = {bus.out_data, bus.out_last_win, bus.out_last};
      end else begin
        stall_prev = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_count", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          eb = exp_q.pop_front();
          chk("beat_data", bus.out_data, eb.d);
          chk("beat_last_win", bus.out_last_win, eb.lw);
          chk("beat_last", bus.out_last, eb.last);
        end
        n_acc++;
      end
      if (done) n_done++;
    end
  end

  always @(negedge clk) begin
    if (cap_s) begin
      if (bus_s.mem_rd_en) addr_s.push_back(int'(bus_s.mem_addr));
      if (bus_s.out_valid && bus_s.out_ready)
        beat_s.push_back({bus_s.out_data, bus_s.out_last_win, bus_s.out_last});
      if (done_s) n_done_s++;
    end
  end

  task automatic run_frame(input int pct, input bit repulse, input bit sod);
    int cyc;
    build_model();
    n_acc = 0; n_issued = 0; n_done = 0; stall_prev = 0; last_pulse = -1;
    ready_pct = pct; repulse_en = repulse; start_on_done = sod;
    mon_en = 1;
    start_req = 1;
    repeat (4) @(negedge clk);
    chk("busy_mid", busy, 1'b1);
    cyc = 0;
    while (n_done == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    chk("done_pulses", n_done, 1);
    chk("beats_total", n_acc, NBEAT);
    chk("beats_left", exp_q.size(), 0);
    chk("addrs_left", exp_addr_q.size(), 0);
    chk("busy_after", busy, 1'b0);
    if (sod) chk("start_at_done_applied", start_on_done, 1'b0);
    mon_en = 0;
    repulse_en = 0;
    start_on_done = 0;
  endtask

  initial begin
    int cyc, nd;
    vec_s[0]  = '{0,  8'h80, 1'b0, 1'b0};
    vec_s[1]  = '{1,  8'h05, 1'b0, 1'b0};
    vec_s[2]  = '{4,  8'hF9, 1'b0, 1'b0};
    vec_s[3]  = '{5,  8'h03, 1'b1, 1'b0};
    vec_s[4]  = '{2,  8'hFD, 1'b0, 1'b0};
    vec_s[5]  = '{3,  8'h07, 1'b0, 1'b0};
    vec_s[6]  = '{6,  8'h9C, 1'b0, 1'b0};
    vec_s[7]  = '{7,  8'hFE, 1'b1, 1'b0};
    vec_s[8]  = '{8,  8'hCE, 1'b0, 1'b0};
    vec_s[9]  = '{9,  8'hC4, 1'b0, 1'b0};
    vec_s[10] = '{12, 8'hBA, 1'b0, 1'b0};
    vec_s[11] = '{13, 8'hC9, 1'b1, 1'b0};
    vec_s[12] = '{10, 8'h7F, 1'b0, 1'b0};
    vec_s[13] = '{11, 8'h00, 1'b0, 1'b0};
    vec_s[14] = '{14, 8'hFF, 1'b0, 1'b0};
    vec_s[15] = '{15, 8'h7E, 1'b1, 1'b1};
    for (int i = 0; i < 16; i++) mem_s[vec_s[i].addr] = vec_s[i].ram;
    for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom);

    start_s = 1'b0;
    bus_s.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, done, bus.mem_rd_en, bus.mem_addr, bus.out_valid, bus.out_data,
                        bus.out_last_win, bus.out_last}, '0);
    chk("rst_outputs_s", {busy_s, done_s, bus_s.mem_rd_en, bus_s.out_valid, bus_s.out_data}, '0);
    rst = 1'b0;

    run_frame(100, 0, 0);
    run_frame(50, 0, 1);
    run_frame(100, 1, 0);

    // Reset in mid-frame with the output path full.
    build_model();
    n_acc = 0; n_issued = 0; n_done = 0; stall_prev = 0;
    ready_pct = 100; mon_en = 1; start_req = 1;
    cyc = 0;
    while (n_acc < 100 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_beat100", n_acc >= 100, 1'b1);
    ready_pct = 0;
    repeat (5) @(negedge clk);
    chk("stalled_valid", bus.out_valid, 1'b1);
    mon_en = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {busy, done, bus.mem_rd_en, bus.mem_addr, bus.out_valid, bus.out_data,
                            bus.out_last_win, bus.out_last}, '0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    run_frame(100, 0, 0);

    // 4x4 instance against the vector table.
    addr_s.delete();
    beat_s.delete();
    n_done_s = 0;
    cap_s = 1;
    @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    cyc = 0;
    while (n_done_s == 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    cap_s = 0;
    chk("small_done", n_done_s, 1);
    chk("small_naddr", addr_s.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < addr_s.size()) chk("small_addr", addr_s[i], vec_s[i].addr);
    chk("small_nbeat", beat_s.size(), NBEAT_S);
`ifdef CONV_RSTL_MAXPOOL_EN
    for (int k = 0; k < 4; k++) begin
      int mx, v;
      mx = -1000;
      for (int j = 0; j < 4; j++) begin
        v = int'($signed(vec_s[4*k+j].ram));
        if (v > mx) mx = v;
      end
      if (k < beat_s.size()) begin
        chk("small_max", beat_s[k].d, DW'(mx));
        chk("small_lw", beat_s[k].lw, 1'b1);
        chk("small_last", beat_s[k].last, k == 3);
      end
    end
`else
    for (int i = 0; i < 16; i++) begin
      if (i < beat_s.size()) begin
        chk("small_data", beat_s[i].d, vec_s[i].ram);
        chk("small_lw", beat_s[i].lw, vec_s[i].lw);
        chk("small_last", beat_s[i].last, vec_s[i].last);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
